ahb_slave_if: RTL and testbench

AHB-Lite slave front end of the AHB-to-APB bridge, directly upstream of the APB controller. It captures and pipelines the AHB address and data phases, and decodes the address into one of three APB peripheral selects. It produces the `valid` qualifier the controller sequences on. It also polices transfers and issues the two-cycle AHB ERROR response for:
- unmapped addresses,
- unsupported sizes,
- malformed bursts.

---
 rtl/ahb_slave_if.sv | 148 ++++++++++++++
 tb/tb_ahb_slave_if.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: address/data pipeline,
// peripheral decode, burst policing and the two-cycle ERROR response.
module ahb_slave_if #(
    parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
    parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    input  logic        apb_ready,
    output logic        valid,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwritereg,
    output logic [2:0]  tempsel,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [4:0]  beats_left;
    logic [31:0] exp_addr;
    logic [2:0]  cur_burst, cur_size;
    logic        burst_open;

    logic        active, viol, seq_bad, fixed_len, accept, enter_err;
    logic [2:0]  nb;
    logic [4:0]  beats;
    logic        wrap;
    logic [31:0] inc, wmask, next_addr;

    // Window check done in 33 bits so a window ending at 4 GB cannot overflow.
    function automatic logic in_win(input logic [31:0] a, input logic [31:0] base);
        return ({1'b0, a} >= {1'b0, base}) &&
               ({1'b0, a} <  ({1'b0, base} + {1'b0, SLV_SIZE}));
    endfunction

    always_comb begin
        tempsel = 3'b000;
        if (in_win(haddr, SLV0_BASE))      tempsel = 3'b001;
        else if (in_win(haddr, SLV1_BASE)) tempsel = 3'b010;
        else if (in_win(haddr, SLV2_BASE)) tempsel = 3'b100;
    end

    assign active    = hreadyin & htrans[1];
    assign fixed_len = (cur_burst[2:1] != 2'b00);
    assign seq_bad   = !burst_open || (cur_burst == 3'b000) ||
                       (fixed_len && (beats_left == 5'd0)) ||
                       (haddr != exp_addr) || (hsize != cur_size);
    assign viol      = (tempsel == 3'b000) || (hsize > 3'd2) || (htrans[0] && seq_bad);
    assign valid     = active && !viol && (state == ST_OK);
    assign accept    = valid;
    assign enter_err = active && viol && (state != ST_ERR1);

    // A SEQ continues the latched burst type; a NONSEQ starts a new one.
    always_comb begin
        nb = htrans[0] ? cur_burst : hburst;
        case (nb[2:1])
            2'b01:   beats = 5'd4;
            2'b10:   beats = 5'd8;
            2'b11:   beats = 5'd16;
            default: beats = 5'd1;
        endcase
        wrap      = !nb[0] && (nb[2:1] != 2'b00);
        inc       = 32'd1 << hsize[1:0];
        wmask     = ({27'd0, beats} << hsize[1:0]) - 32'd1;
        next_addr = wrap ? ((haddr & ~wmask) | ((haddr + inc) & wmask)) : (haddr + inc);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            beats_left <= 5'd0;
            exp_addr   <= 32'd0;
            cur_burst  <= 3'd0;
            cur_size   <= 3'd0;
            burst_open <= 1'b0;
        end else if (enter_err) begin
            beats_left <= 5'd0;
            exp_addr   <= 32'd0;
            cur_burst  <= 3'd0;
            cur_size   <= 3'd0;
            burst_open <= 1'b0;
        end else if (accept) begin
            exp_addr <= next_addr;
            if (!htrans[0]) begin
                beats_left <= beats - 5'd1;
                cur_burst  <= hburst;
                cur_size   <= hsize;
                burst_open <= 1'b1;
            end else if (beats_left != 5'd0) begin
                beats_left <= beats_left - 5'd1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1    <= 32'd0;
            haddr2    <= 32'd0;
            hwdata1   <= 32'd0;
            hwdata2   <= 32'd0;
            hwritereg <= 1'b0;
        end else if (hreadyin) begin
            haddr1    <= haddr;
            haddr2    <= haddr1;
            hwdata1   <= hwdata;
            hwdata2   <= hwdata1;
            hwritereg <= hwrite;
        end
    end

    // A fresh violation sampled during ERR2 restarts the two-cycle response.
    always_comb begin
        state_nxt = ST_OK;
        case (state)
            ST_OK:   state_nxt = enter_err ? ST_ERR1 : ST_OK;
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = (active && viol) ? ST_ERR1 : ST_OK;
            default: state_nxt = ST_OK;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_OK;
        else          state <= state_nxt;
    end

    assign hreadyout = (state == ST_OK) ? apb_ready : (state == ST_ERR2);
    assign hresp     = (state == ST_OK) ? 2'b00 : 2'b01;
    assign hrdata    = prdata;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if: decode, pipeline, error
// response, burst policing and asynchronous reset.
module tb_ahb_slave_if;

    logic        hclk = 1'b0;
    logic        hresetn, hwrite, hreadyin, apb_ready;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] haddr, hwdata, prdata;
    logic        valid, hwritereg, hreadyout;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2, hrdata;
    logic [2:0]  tempsel;
    logic [1:0]  hresp;

    int checks = 0;
    int fails  = 0;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    ahb_slave_if dut (
        .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .haddr(haddr),
        .hwdata(hwdata), .prdata(prdata), .apb_ready(apb_ready), .valid(valid),
        .haddr1(haddr1), .haddr2(haddr2), .hwdata1(hwdata1), .hwdata2(hwdata2),
        .hwritereg(hwritereg), .tempsel(tempsel), .hrdata(hrdata),
        .hreadyout(hreadyout), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [2:0] bu, input logic [31:0] a, input logic [31:0] wd);
        htrans = tr; hwrite = wr; hsize = sz; hburst = bu; haddr = a; hwdata = wd;
        #1;
    endtask

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_two;
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
    endtask

    task automatic test_reset;
        hresetn = 1'b0; hreadyin = 1'b1; apb_ready = 1'b1; prdata = 32'h1234_5678;
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL reset_hresp: got %b expected 00", hresp); end
        checks++; if (hreadyout !== 1'b1) begin fails++; $display("[TB] FAIL reset_hreadyout: got %b expected 1", hreadyout); end
        checks++; if (haddr1 !== 32'h0) begin fails++; $display("[TB] FAIL reset_haddr1: got %h expected 0", haddr1); end
        checks++; if (hrdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL hrdata_pass: got %h expected 12345678", hrdata); end
        tick();
        hresetn = 1'b1;
        tick();
    endtask

    task automatic test_decode_write;
        drive(NSEQ, 1'b1, 3'd2, 3'd0, 32'h8000_0010, 32'hA5A5_0001);
        checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL wr_valid: got %b expected 1", valid); end
        checks++; if (tempsel !== 3'b001) begin fails++; $display("[TB] FAIL wr_tempsel: got %b expected 001", tempsel); end
        tick();
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'hDEAD_BEEF);
        checks++; if (haddr1 !== 32'h8000_0010) begin fails++; $display("[TB] FAIL wr_haddr1: got %h expected 80000010", haddr1); end
        checks++; if (hwritereg !== 1'b1) begin fails++; $display("[TB] FAIL wr_hwritereg: got %b expected 1", hwritereg); end
        checks++; if (hwdata1 !== 32'hA5A5_0001) begin fails++; $display("[TB] FAIL wr_hwdata1: got %h expected a5a50001", hwdata1); end
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_valid: got %b expected 0", valid); end
        tick();
        checks++; if (haddr2 !== 32'h8000_0010) begin fails++; $display("[TB] FAIL wr_haddr2: got %h expected 80000010", haddr2); end
        checks++; if (hwdata2 !== 32'hA5A5_0001) begin fails++; $display("[TB] FAIL wr_hwdata2: got %h expected a5a50001", hwdata2); end
        checks++; if (hwdata1 !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL wr_hwdata1_b: got %h expected deadbeef", hwdata1); end
    endtask

    task automatic test_decode_bounds;
        logic [31:0] addrs [6] = '{32'h8400_0000, 32'h87FF_FFFC, 32'h8800_0000,
                                   32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
        logic [2:0]  sels  [6] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
        hreadyin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(NSEQ, 1'b0, 3'd2, 3'd0, addrs[i], 32'h0);
            checks++; if (tempsel !== sels[i]) begin fails++; $display("[TB] FAIL decode_%0d: got %b expected %b", i, tempsel, sels[i]); end
            checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL notready_valid_%0d: got %b expected 0", i, valid); end
        end
        tick();
        checks++; if (haddr1 !== 32'h0) begin fails++; $display("[TB] FAIL hold_haddr1: got %h expected 0", haddr1); end
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL hold_hresp: got %b expected 00", hresp); end
        hreadyin = 1'b1;
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        apb_ready = 1'b0;
        #1;
        checks++; if (hreadyout !== 1'b0) begin fails++; $display("[TB] FAIL apb_stall: got %b expected 0", hreadyout); end
        apb_ready = 1'b1;
        tick();
    endtask

    task automatic test_unmapped;
        drive(NSEQ, 1'b0, 3'd2, 3'd0, 32'h9000_0000, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL unmap_valid: got %b expected 0", valid); end
        checks++; if (tempsel !== 3'b000) begin fails++; $display("[TB] FAIL unmap_tempsel: got %b expected 000", tempsel); end
        tick();
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        checks++; if ({hreadyout, hresp} !== 3'b001) begin fails++; $display("[TB] FAIL unmap_err1: got %b expected 001", {hreadyout, hresp}); end
        tick();
        checks++; if ({hreadyout, hresp} !== 3'b101) begin fails++; $display("[TB] FAIL unmap_err2: got %b expected 101", {hreadyout, hresp}); end
        tick();
        checks++; if ({hreadyout, hresp} !== 3'b100) begin fails++; $display("[TB] FAIL unmap_okay: got %b expected 100", {hreadyout, hresp}); end
    endtask

    task automatic test_wrap4;
        logic [31:0] seq_addr [4] = '{32'h8400_0008, 32'h8400_000C, 32'h8400_0000, 32'h8400_0004};
        for (int i = 0; i < 4; i++) begin
            drive(i == 0 ? NSEQ : SEQ, 1'b0, 3'd2, 3'b010, seq_addr[i], 32'h0);
            checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL wrap4_valid_%0d: got %b expected 1", i, valid); end
            tick();
            checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL wrap4_resp_%0d: got %b expected 00", i, hresp); end
        end
        drive(SEQ, 1'b0, 3'd2, 3'b010, 32'h8400_0008, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL wrap4_fifth_valid: got %b expected 0", valid); end
        tick();
        checks++; if ({hreadyout, hresp} !== 3'b001) begin fails++; $display("[TB] FAIL wrap4_fifth_err: got %b expected 001", {hreadyout, hresp}); end
        idle_two();
    endtask

    task automatic test_incr4_bad_addr;
        drive(NSEQ, 1'b1, 3'd2, 3'b011, 32'h8800_0000, 32'h0);
        checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL incr4_b1: got %b expected 1", valid); end
        tick();
        drive(SEQ, 1'b1, 3'd2, 3'b011, 32'h8800_0004, 32'h0);
        checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL incr4_b2: got %b expected 1", valid); end
        tick();
        drive(SEQ, 1'b1, 3'd2, 3'b011, 32'h8800_0010, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL incr4_b3_valid: got %b expected 0", valid); end
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL incr4_b3_resp: got %b expected 00", hresp); end
        tick();
        checks++; if ({hreadyout, hresp} !== 3'b001) begin fails++; $display("[TB] FAIL incr4_err: got %b expected 001", {hreadyout, hresp}); end
        idle_two();
    endtask

    task automatic test_bad_size_and_err2;
        drive(NSEQ, 1'b0, 3'd3, 3'd0, 32'h8000_0000, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL size3_valid: got %b expected 0", valid); end
        tick();
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        checks++; if (hresp !== 2'b01) begin fails++; $display("[TB] FAIL size3_err: got %b expected 01", hresp); end
        tick();
        drive(NSEQ, 1'b0, 3'd2, 3'd0, 32'h8000_0000, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL err2_discard: got %b expected 0", valid); end
        tick();
        checks++; if ({hreadyout, hresp} !== 3'b100) begin fails++; $display("[TB] FAIL err2_to_ok: got %b expected 100", {hreadyout, hresp}); end
        drive(SEQ, 1'b0, 3'd2, 3'd0, 32'h8000_0004, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL seq_no_nonseq: got %b expected 0", valid); end
        tick();
        idle_two();
    endtask

    task automatic test_busy;
        drive(NSEQ, 1'b0, 3'd2, 3'b101, 32'h8000_0100, 32'h0);
        tick();
        drive(SEQ, 1'b0, 3'd2, 3'b101, 32'h8000_0104, 32'h0);
        checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL busy_b2: got %b expected 1", valid); end
        tick();
        drive(BUSY, 1'b0, 3'd2, 3'b101, 32'h8000_0108, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL busy_valid: got %b expected 0", valid); end
        tick();
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL busy_resp: got %b expected 00", hresp); end
        drive(SEQ, 1'b0, 3'd2, 3'b101, 32'h8000_0108, 32'h0);
        checks++; if (valid !== 1'b1) begin fails++; $display("[TB] FAIL busy_resume: got %b expected 1", valid); end
        tick();
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL busy_resume_resp: got %b expected 00", hresp); end
        drive(IDLE, 1'b0, 3'd2, 3'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_burst;
        drive(NSEQ, 1'b1, 3'd2, 3'b011, 32'h8000_0000, 32'h1111_1111);
        tick();
        drive(SEQ, 1'b1, 3'd2, 3'b011, 32'h8000_0004, 32'h2222_2222);
        hresetn = 1'b0;
        #1;
        checks++; if ({haddr1, haddr2} !== 64'h0) begin fails++; $display("[TB] FAIL rst_haddr: got %h expected 0", {haddr1, haddr2}); end
        checks++; if ({hwdata1, hwdata2} !== 64'h0) begin fails++; $display("[TB] FAIL rst_hwdata: got %h expected 0", {hwdata1, hwdata2}); end
        checks++; if (hresp !== 2'b00) begin fails++; $display("[TB] FAIL rst_hresp: got %b expected 00", hresp); end
        tick();
        hresetn = 1'b1;
        drive(SEQ, 1'b1, 3'd2, 3'b011, 32'h8000_0008, 32'h0);
        checks++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_seq_valid: got %b expected 0", valid); end
        tick();
        checks++; if (hresp !== 2'b01) begin fails++; $display("[TB] FAIL rst_seq_err: got %b expected 01", hresp); end
        idle_two();
    endtask

    initial begin
        test_reset();
        test_decode_write();
        test_decode_bounds();
        test_unmapped();
        test_wrap4();
        test_incr4_bad_addr();
        test_bad_size_and_err2();
        test_busy();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
